// File: rtl/subleq_mem_ctrl.sv
// SUBLEQ main memory: zero-fills the array after reset, streams in a boot image
// from the loader port, then serves single-cycle load/store requests from the core.
module subleq_mem_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16,
    parameter int DEPTH     = 65536
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 ld_valid,
    input  logic [WORD_SIZE-1:0] ld_data,
    input  logic                 ld_last,
    output logic                 ld_ready,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 rsp_valid,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int                 PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_SIZE:0] DEPTH_EXT = (ADDR_SIZE + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t               r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic                 r_ld_ready;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic                 r_rsp_err;
    logic [WORD_SIZE-1:0] r_rsp_rdata;
    logic                 r_busy;

    logic                 w_ld_fire;
    logic                 w_req_fire;
    logic                 w_in_range;
    logic [PTR_W-1:0]     w_req_idx;
    logic                 w_mem_we;
    logic [PTR_W-1:0]     w_mem_waddr;
    logic [WORD_SIZE-1:0] w_mem_wdata;

    assign w_ld_fire  = ld_valid & r_ld_ready & (r_state == ST_LOAD);
    assign w_req_fire = req_valid & r_req_ready & (r_state == ST_RUN);
    // Compare one bit wider so DEPTH == 2**ADDR_SIZE needs no special case.
    assign w_in_range = ({1'b0, req_addr} < DEPTH_EXT);
    assign w_req_idx  = req_addr[PTR_W-1:0];

    // Select the single write port source for the current phase.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = r_ptr;
        w_mem_wdata = '0;
        case (r_state)
            ST_CLEAR: begin
                w_mem_we = areset_n;
            end
            ST_LOAD: begin
                if (w_ld_fire) begin
                    w_mem_we    = areset_n;
                    w_mem_wdata = ld_data;
                end else begin
                    w_mem_we = 1'b0;
                end
            end
            ST_RUN: begin
                if (w_req_fire && req_we && w_in_range) begin
                    w_mem_we    = areset_n;
                    w_mem_waddr = w_req_idx;
                    w_mem_wdata = req_wdata;
                end else begin
                    w_mem_we = 1'b0;
                end
            end
            default: begin
                w_mem_we = 1'b0;
            end
        endcase
    end

    // Storage array, left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Boot sequencer FSM and registered response path.
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            r_state     <= ST_CLEAR;
            r_ptr       <= '0;
            r_ld_ready  <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_busy      <= 1'b1;
        end else begin
            r_rsp_valid <= w_req_fire;
            r_rsp_err   <= w_req_fire & ~w_in_range;
            if (w_req_fire && !req_we && w_in_range) begin
                r_rsp_rdata <= r_mem[w_req_idx];
            end else begin
                r_rsp_rdata <= '0;
            end
            case (r_state)
                ST_CLEAR: begin
                    if (r_ptr == LAST_PTR) begin
                        r_ptr      <= '0;
                        r_state    <= ST_LOAD;
                        r_ld_ready <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + PTR_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (w_ld_fire) begin
                        if (ld_last || (r_ptr == LAST_PTR)) begin
                            r_state     <= ST_RUN;
                            r_ld_ready  <= 1'b0;
                            r_req_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_ptr <= r_ptr + PTR_W'(1);
                        end
                    end else begin
                        r_ptr <= r_ptr;
                    end
                end
                ST_RUN: begin
                    r_ld_ready  <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= ST_CLEAR;
                    r_ptr       <= '0;
                    r_ld_ready  <= 1'b0;
                    r_req_ready <= 1'b0;
                    r_busy      <= 1'b1;
                end
            endcase
        end
    end

    assign ld_ready  = r_ld_ready;
    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_subleq_mem_ctrl.sv
// Directed plus randomized bench for subleq_mem_ctrl (DEPTH=16, ADDR_SIZE=8),
// checked against an array model updated from the memory's load/store rules.
module tb_subleq_mem_ctrl;

    localparam int W = 16;
    localparam int A = 8;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         areset_n;
    logic         ld_valid;
    logic [W-1:0] ld_data;
    logic         ld_last;
    logic         ld_ready;
    logic         req_valid;
    logic         req_we;
    logic [A-1:0] req_addr;
    logic [W-1:0] req_wdata;
    logic         req_ready;
    logic         rsp_valid;
    logic [W-1:0] rsp_rdata;
    logic         rsp_err;
    logic         busy;

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] model [D];
    logic [W-1:0] img   [D];
    bit           exp_run;
    bit           pend_v;
    bit           pend_err;
    logic [W-1:0] pend_rd;

    always #5 clk = ~clk;

    subleq_mem_ctrl #(.WORD_SIZE(W), .ADDR_SIZE(A), .DEPTH(D)) dut (
        .clk(clk), .areset_n(areset_n),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of CPU traffic: check the response owed from the previous cycle, then issue.
    task automatic cyc(input bit v, input bit we, input logic [A-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, pend_v});
        chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, pend_rd});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, pend_err});
        chk("req_ready", {31'd0, req_ready}, {31'd0, exp_run});
        if (exp_run) chk("ld_ready_run", {31'd0, ld_ready}, 32'd0);
        pend_v   = v && exp_run;
        pend_rd  = '0;
        pend_err = 1'b0;
        if (pend_v) begin
            if (a >= A'(D)) begin
                pend_err = 1'b1;
            end else begin
                if (!we) pend_rd = model[a[3:0]];
                else     model[a[3:0]] = d;
            end
        end
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic read_all();
        for (int a = 0; a < D; a++) cyc(1'b1, 1'b0, A'(a), 16'h0000);
        cyc(1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    // Reset, then follow CLEAR for exactly DEPTH cycles with a request held on the port.
    task automatic do_reset();
        @(negedge clk);
        areset_n  = 1'b0;
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h00;
        req_wdata = 16'hFFFF;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        areset_n = 1'b1;
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            chk("clr_busy", {31'd0, busy}, 32'd1);
            chk("clr_ld_ready", {31'd0, ld_ready}, (i == D - 1) ? 32'd1 : 32'd0);
            chk("clr_req_ready", {31'd0, req_ready}, 32'd0);
            chk("clr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        req_valid = 1'b0;
        for (int i = 0; i < D; i++) model[i] = '0;
        exp_run  = 1'b0;
        pend_v   = 1'b0;
        pend_rd  = '0;
        pend_err = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("load_wait_ready", {31'd0, ld_ready}, 32'd1);
            chk("load_wait_busy", {31'd0, busy}, 32'd1);
        end
    endtask

    // Stream img[0..n-1], with random idle gaps; RUN follows ld_last or the DEPTH-th word.
    task automatic load_img(input int n, input bit use_last);
        bit done;
        done = 1'b0;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
                @(negedge clk);
                chk("gap_ld_ready", {31'd0, ld_ready}, 32'd1);
            end
            ld_valid = 1'b1;
            ld_data  = img[k];
            ld_last  = use_last && (k == n - 1);
            model[k] = img[k];
            @(negedge clk);
            done = ld_last || (k == D - 1);
            chk("ld_ready", {31'd0, ld_ready}, {31'd0, !done});
            chk("ld_busy", {31'd0, busy}, {31'd0, !done});
            chk("ld_req_ready", {31'd0, req_ready}, {31'd0, done});
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        exp_run  = done;
    endtask

    initial begin
        areset_n  = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        ld_last   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // Full image without ld_last; extra loader words in RUN are ignored.
        do_reset();
        for (int i = 0; i < D; i++) img[i] = W'($urandom);
        load_img(D, 1'b0);
        ld_valid = 1'b1;
        ld_data  = 16'hBEEF;
        ld_last  = 1'b1;
        read_all();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        for (int i = 0; i < 40; i++)
            cyc(1'b1, 1'b1, A'($urandom_range(0, D - 1)), W'($urandom));
        cyc(1'b0, 1'b0, 8'h00, 16'h0000);

        // Short image 3,7,FFFF; remaining words come back zero from CLEAR.
        do_reset();
        img[0] = 16'h0003;
        img[1] = 16'h0007;
        img[2] = 16'hFFFF;
        load_img(3, 1'b1);
        read_all();

        // Read-after-write on consecutive cycles.
        cyc(1'b1, 1'b1, 8'd5, 16'h1234);
        cyc(1'b1, 1'b0, 8'd5, 16'h0000);
        cyc(1'b0, 1'b0, 8'd0, 16'h0000);

        // Out-of-range load and store.
        cyc(1'b1, 1'b0, 8'd20, 16'h0000);
        cyc(1'b1, 1'b1, 8'd20, 16'h0009);
        cyc(1'b1, 1'b1, 8'hFF, 16'hAAAA);
        cyc(1'b0, 1'b0, 8'd0, 16'h0000);
        read_all();

        // Random back-to-back traffic including out-of-range addresses.
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 3) != 0, 1'($urandom), A'($urandom_range(0, 23)), W'($urandom));
        cyc(1'b0, 1'b0, 8'd0, 16'h0000);
        read_all();

        // Reset in the middle of LOAD, then a one-word image.
        do_reset();
        img[0] = 16'h1111;
        img[1] = 16'h2222;
        load_img(2, 1'b0);
        do_reset();
        img[0] = W'($urandom_range(1, 16'hFFFF));
        load_img(1, 1'b1);
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
